// File: rtl/cmul_arb_pkg.sv
// Shared definitions for the complex-multiplier round-robin arbiter:
// data width, default multiplier latency, id width helper and tag record.
package cmul_arb_pkg;

  // Operand/result width of the FP32 complex multiplier (per component)
  localparam int FP_W = 32;

  // Default multiplier latency, mul_enable to mul_valid
  localparam int DEFAULT_LATENCY = 7;

  // Tag id field is sized for the largest supported requester count (8)
  localparam int TAG_ID_W = 3;

  // Width of an encoded requester id; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One tag pipeline stage: whether an operation occupies this slot and who issued it
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cmul_rr_pick.sv
// Combinational round-robin picker. The search starts one past ptr and
// wraps; the first eligible requester wins. Produces a one-hot grant and
// its encoded id. Usable by any arbiter in front of a shared unit.
module cmul_rr_pick
  import cmul_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]             elig,
  input  logic [id_width(N)-1:0]   ptr,
  output logic [N-1:0]             grant,
  output logic [id_width(N)-1:0]   grant_id
);

  localparam int IDW = id_width(N);

  logic found;

  // Pass one scans ids above ptr, pass two wraps around to ptr and below
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i] && (i > int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i] && (i <= int'(ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/cmul_rr_arbiter.sv
// Round-robin front end sharing one pipelined FP32 complex multiplier
// between NUM_REQ requesters. One operation is issued per cycle at most;
// a tag shift register follows each operation through the multiplier so
// the result can be steered back to its requester. Per-requester
// outstanding counters stop a requester from exceeding MAX_OUTST in-flight
// operations, because responses cannot be stalled.
//
// The external multiplier's active-low reset must be tied to ~rst so that
// it drops its in-flight work together with the tag pipeline.
//
// Optional build macro CMUL_ARB_PERF_EN adds perf_issue_cnt and
// perf_stall_cnt saturating counters.
module cmul_rr_arbiter
  import cmul_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = DEFAULT_LATENCY,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*FP_W-1:0]      req_a_real,
  input  logic [NUM_REQ*FP_W-1:0]      req_a_imag,
  input  logic [NUM_REQ*FP_W-1:0]      req_c_real,
  input  logic [NUM_REQ*FP_W-1:0]      req_c_imag,
  output logic                         mul_enable,
  output logic [FP_W-1:0]              mul_a_real,
  output logic [FP_W-1:0]              mul_a_imag,
  output logic [FP_W-1:0]              mul_c_real,
  output logic [FP_W-1:0]              mul_c_imag,
  input  logic [FP_W-1:0]              mul_result_real,
  input  logic [FP_W-1:0]              mul_result_imag,
  input  logic                         mul_valid,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [FP_W-1:0]              rsp_real,
  output logic [FP_W-1:0]              rsp_imag,
  output logic [id_width(NUM_REQ)-1:0] rsp_id,
`ifdef CMUL_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]        perf_issue_cnt,
  output logic [15:0]                  perf_stall_cnt,
`endif
  output logic                         tag_err
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = 4;
  localparam logic [CW-1:0] CAP = CW'(MAX_OUTST);

  logic [CW-1:0]      outst [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     ptr;
  logic               accept;

  logic [FP_W-1:0]    sel_a_real;
  logic [FP_W-1:0]    sel_a_imag;
  logic [FP_W-1:0]    sel_c_real;
  logic [FP_W-1:0]    sel_c_imag;

  logic [TAG_ID_W-1:0] issue_id;
  tag_t                tag_pipe [LATENCY];
  tag_t                tag_out;
  logic                rsp_fire;

  // A requester may compete only while it still has credit left
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (outst[i] < CAP);
    end
  end

  cmul_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .elig     (elig),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign accept    = |(grant & req_valid);

  // Select the winner's operands out of the packed request buses
  always_comb begin
    sel_a_real = '0;
    sel_a_imag = '0;
    sel_c_real = '0;
    sel_c_imag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a_real = req_a_real[i*FP_W +: FP_W];
        sel_a_imag = req_a_imag[i*FP_W +: FP_W];
        sel_c_real = req_c_real[i*FP_W +: FP_W];
        sel_c_imag = req_c_imag[i*FP_W +: FP_W];
      end
    end
  end

  // Round-robin pointer remembers the last winner; idle cycles leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= grant_id;
    end
  end

  // Issue register: operands hold their last values when nothing is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_enable <= 1'b0;
      mul_a_real <= '0;
      mul_a_imag <= '0;
      mul_c_real <= '0;
      mul_c_imag <= '0;
      issue_id   <= '0;
    end else begin
      mul_enable <= accept;
      if (accept) begin
        mul_a_real <= sel_a_real;
        mul_a_imag <= sel_a_imag;
        mul_c_real <= sel_c_real;
        mul_c_imag <= sel_c_imag;
        issue_id   <= TAG_ID_W'(grant_id);
      end
    end
  end

  // Tag shift register runs beside the multiplier so its last stage lines up with mul_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: mul_enable, id: issue_id};
      for (int k = 1; k < LATENCY; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign tag_out  = tag_pipe[LATENCY-1];
  assign rsp_fire = mul_valid && tag_out.valid;
  assign rsp_id   = tag_out.id[IDW-1:0];
  assign rsp_real = mul_result_real;
  assign rsp_imag = mul_result_imag;

  // Response strobe goes only to the requester named by the tag
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = rsp_fire && (tag_out.id == TAG_ID_W'(i));
    end
  end

  // Sticky flag for a multiplier result that does not match the tag pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_err <= 1'b0;
    end else if (mul_valid != tag_out.valid) begin
      tag_err <= 1'b1;
    end
  end

  // Credit counters: up on acceptance, down on response, unchanged when both happen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        outst[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({grant[i], rsp_valid[i]})
          2'b10:   if (outst[i] != CAP) outst[i] <= outst[i] + CW'(1);
          2'b01:   if (outst[i] != '0)  outst[i] <= outst[i] - CW'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef CMUL_ARB_PERF_EN
  logic [15:0] issue_cnt [NUM_REQ];
  logic [15:0] stall_cnt;

  // Saturating per-requester acceptance counters and a shared stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        issue_cnt[i] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (issue_cnt[i] != 16'hFFFF)) begin
          issue_cnt[i] <= issue_cnt[i] + 16'd1;
        end
      end
      if ((|req_valid) && !accept && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_pack
    assign perf_issue_cnt[g*16 +: 16] = issue_cnt[g];
  end

  assign perf_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_cmul_rr_arbiter.sv
// Self-checking bench for cmul_rr_arbiter (default build, 4 requesters).
// A stand-in multiplier with the real 7-cycle latency returns a value
// derived from its operands, so misrouted or mistimed results are visible;
// for the 1+2j by 3+4j vector it returns the true product -5+10j.
module tb_cmul_rr_arbiter;

  localparam int NUM = 4;
  localparam int LAT = 7;
  localparam int W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NUM-1:0]   req_valid;
  logic [NUM-1:0]   req_ready;
  logic [NUM*W-1:0] req_a_real;
  logic [NUM*W-1:0] req_a_imag;
  logic [NUM*W-1:0] req_c_real;
  logic [NUM*W-1:0] req_c_imag;
  logic             mul_enable;
  logic [W-1:0]     mul_a_real;
  logic [W-1:0]     mul_a_imag;
  logic [W-1:0]     mul_c_real;
  logic [W-1:0]     mul_c_imag;
  logic [W-1:0]     mul_result_real;
  logic [W-1:0]     mul_result_imag;
  logic             mul_valid;
  logic [NUM-1:0]   rsp_valid;
  logic [W-1:0]     rsp_real;
  logic [W-1:0]     rsp_imag;
  logic [1:0]       rsp_id;
  logic             tag_err;

  always #5 clk = ~clk;

  cmul_rr_arbiter #(
    .NUM_REQ   (NUM),
    .LATENCY   (LAT),
    .MAX_OUTST (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a_real      (req_a_real),
    .req_a_imag      (req_a_imag),
    .req_c_real      (req_c_real),
    .req_c_imag      (req_c_imag),
    .mul_enable      (mul_enable),
    .mul_a_real      (mul_a_real),
    .mul_a_imag      (mul_a_imag),
    .mul_c_real      (mul_c_real),
    .mul_c_imag      (mul_c_imag),
    .mul_result_real (mul_result_real),
    .mul_result_imag (mul_result_imag),
    .mul_valid       (mul_valid),
    .rsp_valid       (rsp_valid),
    .rsp_real        (rsp_real),
    .rsp_imag        (rsp_imag),
    .rsp_id          (rsp_id),
    .tag_err         (tag_err)
  );

  // Stand-in multiplier result: exact for the known vector, a cheap mix otherwise
  function automatic logic [63:0] cmulModel(input logic [31:0] ar, input logic [31:0] ai,
                                            input logic [31:0] cr, input logic [31:0] ci);
    if (ar == 32'h3F800000 && ai == 32'h40000000 && cr == 32'h40400000 && ci == 32'h40800000)
      return {32'hC0A00000, 32'h41200000};
    return {ar ^ {cr[15:0], cr[31:16]}, ai + ci};
  endfunction

  typedef struct packed {
    logic        v;
    logic [31:0] r;
    logic [31:0] i;
  } mstage_t;

  mstage_t mpipe [LAT];
  logic    injectValid;

  // Multiplier pipeline model, reset by the same rst (its rst_n is ~rst)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) mpipe[k] <= '0;
    end else begin
      mpipe[0] <= {mul_enable, cmulModel(mul_a_real, mul_a_imag, mul_c_real, mul_c_imag)};
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
  end

  assign mul_valid       = mpipe[LAT-1].v | injectValid;
  assign mul_result_real = mpipe[LAT-1].r;
  assign mul_result_imag = mpipe[LAT-1].i;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] r;
    logic [31:0] i;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] ready;
  } vec_t;

  exp_t        sbQ[$];
  vec_t        tbl[8];
  int          testCount;
  int          failCount;
  int          cyc;
  logic        prevAccept;
  logic [31:0] prevOps[4];
  logic [3:0]  lastReady;
  logic        expectTagErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests, then record what got accepted
  task automatic applyStimulus(input logic [3:0] vld, input bit fixedOp);
    exp_t        e;
    logic [63:0] res;
    for (int i = 0; i < NUM; i++) begin
      req_a_real[i*W +: W] = $urandom();
      req_a_imag[i*W +: W] = $urandom();
      req_c_real[i*W +: W] = $urandom();
      req_c_imag[i*W +: W] = $urandom();
    end
    if (fixedOp) begin
      req_a_real[W-1:0] = 32'h3F800000;
      req_a_imag[W-1:0] = 32'h40000000;
      req_c_real[W-1:0] = 32'h40400000;
      req_c_imag[W-1:0] = 32'h40800000;
    end
    req_valid = vld;
    #1;
    lastReady  = req_ready;
    prevAccept = 1'b0;
    check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    for (int i = 0; i < NUM; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        prevAccept = 1'b1;
        prevOps[0] = req_a_real[i*W +: W];
        prevOps[1] = req_a_imag[i*W +: W];
        prevOps[2] = req_c_real[i*W +: W];
        prevOps[3] = req_c_imag[i*W +: W];
        res   = cmulModel(prevOps[0], prevOps[1], prevOps[2], prevOps[3]);
        e.id  = 2'(i);
        e.r   = res[63:32];
        e.i   = res[31:0];
        e.due = cyc + 1 + LAT;
        sbQ.push_back(e);
      end
    end
  endtask

  // Compare issue port, tag_err and any response against the scoreboard
  task automatic checkOutput();
    exp_t e;
    check("mul_enable", 32'(mul_enable), 32'(prevAccept));
    if (prevAccept) begin
      check("mul_a_real", mul_a_real, prevOps[0]);
      check("mul_a_imag", mul_a_imag, prevOps[1]);
      check("mul_c_real", mul_c_real, prevOps[2]);
      check("mul_c_imag", mul_c_imag, prevOps[3]);
    end
    check("tag_err", 32'(tag_err), 32'(expectTagErr));
    if (rsp_valid != 4'b0000) begin
      if (sbQ.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sbQ.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.id));
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_real", rsp_real, e.r);
        check("rsp_imag", rsp_imag, e.i);
        check("rsp_latency", 32'(cyc), 32'(e.due));
      end
    end else if (sbQ.size() != 0 && sbQ[0].due <= cyc) begin
      e = sbQ.pop_front();
      check("rsp_missing", 32'(rsp_valid), 32'(4'b0001 << e.id));
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic runCycle(input logic [3:0] vld);
    applyStimulus(vld, 1'b0);
    nextCycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) runCycle(4'b0000);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cnt[4];
    logic [3:0]  expG;
    logic [19:0] pat;

    rst          = 1'b1;
    req_valid    = '0;
    req_a_real   = '0;
    req_a_imag   = '0;
    req_c_real   = '0;
    req_c_imag   = '0;
    injectValid  = 1'b0;
    testCount    = 0;
    failCount    = 0;
    cyc          = 0;
    prevAccept   = 1'b0;
    expectTagErr = 1'b0;
    for (int i = 0; i < 4; i++) prevOps[i] = '0;

    tbl[0] = '{4'b1111, 4'b0010};
    tbl[1] = '{4'b0001, 4'b0001};
    tbl[2] = '{4'b0000, 4'b0000};
    tbl[3] = '{4'b1001, 4'b1000};
    tbl[4] = '{4'b1001, 4'b0001};
    tbl[5] = '{4'b0101, 4'b0100};
    tbl[6] = '{4'b0100, 4'b0100};
    tbl[7] = '{4'b0011, 4'b0001};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mul_enable", 32'(mul_enable), 32'd0);
    check("rst_mul_a_real", mul_a_real, 32'd0);
    check("rst_mul_c_imag", mul_c_imag, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_tag_err", 32'(tag_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Single operation from requester 0: response eight cycles later
    applyStimulus(4'b0001, 1'b1);
    check("single_ready", 32'(lastReady), 32'd1);
    nextCycle();
    for (int k = 0; k < 7; k++) runCycle(4'b0000);
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_real", rsp_real, 32'hC0A00000);
    check("single_rsp_imag", rsp_imag, 32'h41200000);
    check("single_rsp_id", 32'(rsp_id), 32'd0);
    idle(4);

    // Arbitration table, pointer starting at 0
    for (int k = 0; k < 8; k++) begin
      applyStimulus(tbl[k].vld, 1'b0);
      check("arb_tbl", 32'(lastReady), 32'(tbl[k].ready));
      nextCycle();
    end
    idle(12);

    // Fairness: all requesters valid for 12 cycles
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(4'b1111, 1'b0);
      expG = 4'b0001 << ((k + 1) % 4);
      check("fair_grant", 32'(lastReady), 32'(expG));
      for (int i = 0; i < 4; i++) if (lastReady[i]) cnt[i]++;
      nextCycle();
      check("fair_mul_enable", 32'(mul_enable), 32'd1);
    end
    for (int i = 0; i < 4; i++) check("fair_count", 32'(cnt[i]), 32'd3);
    idle(12);

    // Credit cap with requester 2 alone; includes same-cycle accept and response
    pat = 20'hC1E0F;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b0100, 1'b0);
      check("credit_ready", 32'(lastReady), pat[k] ? 32'h4 : 32'h0);
      nextCycle();
    end
    idle(12);

    // Reset with five operations in flight
    for (int k = 0; k < 5; k++) runCycle(4'b1111);
    req_valid  = 4'b0000;
    rst        = 1'b1;
    prevAccept = 1'b0;
    #1;
    check("midrst_mul_enable", 32'(mul_enable), 32'd0);
    check("midrst_mul_a_real", mul_a_real, 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_tag_err", 32'(tag_err), 32'd0);
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      runCycle(4'b0000);
      check("midrst_quiet", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(4'b1111, 1'b0);
    check("midrst_ptr", 32'(lastReady), 32'h2);
    nextCycle();
    idle(10);

    // Spurious mul_valid with an empty tag pipeline
    injectValid = 1'b1;
    #1;
    check("tagerr_no_rsp", 32'(rsp_valid), 32'd0);
    expectTagErr = 1'b1;
    nextCycle();
    injectValid = 1'b0;
    idle(3);
    check("tagerr_sticky", 32'(tag_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
